fibo_sequencer: RTL and testbench

Initiator for the Fibonacci unit's start/i/finish/result request interface. Given an index range, it issues one request per index, waits for each completion, and streams (index, result) pairs out over a valid/ready port. It sits between control logic and the Fibo core so that no caller has to sequence the core's handshake by hand.

---
 rtl/fibo_pkg.sv | 16 +
 rtl/fibo_seq_timer.sv | 39 +++
 rtl/fibo_sequencer.sv | 149 ++++++++++++++
 tb/tb_fibo_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// fibo_pkg: widths shared with the Fibo core and the sequencer state
// encoding used by fibo_sequencer.
package fibo_pkg;

    localparam int FIBO_IDX_W = 5;
    localparam int FIBO_RES_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RELEASE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } fibo_seq_state_t;

endpackage

// File: rtl/fibo_seq_timer.sv
// fibo_seq_timer: loadable down-counter with clear; expire_o flags an
// enabled count that has reached zero.
module fibo_seq_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/fibo_sequencer.sv
// fibo_sequencer: walks an index range through the Fibo core handshake and
// streams (index, result) beats. Optional: FIBO_SEQ_TIMEOUT_EN.
module fibo_sequencer
    import fibo_pkg::*;
#(
    parameter int IDX_W       = FIBO_IDX_W,
    parameter int RES_W       = FIBO_RES_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    output logic             busy,
    output logic             done,
    output logic             fibo_start,
    output logic [IDX_W-1:0] fibo_i,
    input  logic             fibo_finish,
    input  logic [RES_W-1:0] fibo_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [RES_W-1:0] out_result,
    output logic             timeout_err
);

    fibo_seq_state_t  state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             expire;
    logic             err_set;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        idx_d   = idx_q;
        res_d   = res_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    cur_d   = first_idx;
                    last_d  = last_idx;
                    state_d = (first_idx > last_idx) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (fibo_finish) begin
                    res_d   = fibo_result;
                    idx_d   = cur_q;
                    state_d = ST_RELEASE;
                end else if (expire) begin
                    err_set = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RELEASE: begin
                if (!fibo_finish) begin
                    state_d = ST_EMIT;
                end else if (expire) begin
                    err_set = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EMIT: begin
                // compare before increment so an all-ones last index never wraps
                if (out_ready) begin
                    if (cur_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + IDX_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign fibo_start = (state_q == ST_REQ);
    assign fibo_i     = cur_q;
    assign out_valid  = (state_q == ST_EMIT);
    assign out_idx    = idx_q;
    assign out_result = res_q;

`ifdef FIBO_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic waiting;
    logic err_q;

    assign waiting = (state_q == ST_REQ) || (state_q == ST_RELEASE);

    // reload on every state change so each handshake edge gets a full budget
    fibo_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (state_d != state_q),
        .load_val_i(CNT_W'(TIMEOUT_CYC - 1)),
        .clr_i     (!waiting),
        .en_i      (waiting),
        .expire_o  (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && go) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC != 0) ^ err_set;
    assign expire         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_sequencer.sv
// tb_fibo_sequencer: directed tests of fibo_sequencer against a small
// behavioural Fibo core with adjustable latency.
module tb_fibo_sequencer;

    localparam int IDX_W = 5;
    localparam int RES_W = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic [IDX_W-1:0] first_idx = '0;
    logic [IDX_W-1:0] last_idx = '0;
    logic             busy;
    logic             done;
    logic             fibo_start;
    logic [IDX_W-1:0] fibo_i;
    logic             fibo_finish;
    logic [RES_W-1:0] fibo_result;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [IDX_W-1:0] out_idx;
    logic [RES_W-1:0] out_result;
    logic             timeout_err;

    int vectors = 0;
    int miscompares = 0;

    int  core_lat = 2;
    bit  core_dead = 1'b0;
    int  lat_cnt;
    logic             core_fin;
    logic [RES_W-1:0] core_res;

    int  beat_idx[$];
    int  beat_res[$];
    int  done_cnt = 0;
    int  start_cnt = 0;
    bit  start_prev = 1'b0;

    always #5 clk = ~clk;

    fibo_sequencer #(
        .IDX_W      (IDX_W),
        .RES_W      (RES_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .busy       (busy),
        .done       (done),
        .fibo_start (fibo_start),
        .fibo_i     (fibo_i),
        .fibo_finish(fibo_finish),
        .fibo_result(fibo_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_result (out_result),
        .timeout_err(timeout_err)
    );

    function automatic logic [RES_W-1:0] fib(input logic [IDX_W-1:0] n);
        logic [RES_W-1:0] a, b, t;
        a = '0;
        b = 1;
        for (int k = 0; k < int'(n); k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // return-to-zero core: finish after core_lat cycles, drop once start drops
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_fin <= 1'b0;
            core_res <= '0;
            lat_cnt  <= 0;
        end else if (core_fin) begin
            if (!fibo_start) core_fin <= 1'b0;
        end else if (fibo_start && !core_dead) begin
            if (lat_cnt >= core_lat) begin
                core_fin <= 1'b1;
                core_res <= fib(fibo_i);
                lat_cnt  <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    assign fibo_finish = core_fin;
    assign fibo_result = core_res;

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                beat_idx.push_back(int'(out_idx));
                beat_res.push_back(int'(out_result));
            end
            if (done) done_cnt++;
            if (fibo_start && !start_prev) start_cnt++;
            start_prev = fibo_start;
        end else begin
            start_prev = 1'b0;
        end
    end

    task automatic start_run(input int f, input int l);
        @(posedge clk);
        #1;
        first_idx = IDX_W'(f);
        last_idx  = IDX_W'(l);
        go        = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, fibo_start, out_valid, timeout_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, done, fibo_start, out_valid, timeout_err});
        end
        vectors++;
        if (out_idx !== '0 || out_result !== '0 || fibo_i !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got idx %0d res %0d i %0d expected 0 0 0",
                     out_idx, out_result, fibo_i);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int d0;
        beat_idx.delete();
        beat_res.delete();
        d0 = done_cnt;
        out_ready = 1'b1;
        core_lat = 2;
        start_run(5, 5);
        vectors++;
        if (busy !== 1'b1 || fibo_start !== 1'b1 || fibo_i !== 5'd5) begin
            miscompares++;
            $display("FAIL single_req: got busy %b start %b i %0d expected 1 1 5",
                     busy, fibo_start, fibo_i);
        end
        wait_done(100, "single");
        vectors++;
        if (beat_idx.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d beats expected 1", beat_idx.size());
        end else begin
            vectors++;
            if (beat_idx[0] != 5 || beat_res[0] != 5) begin
                miscompares++;
                $display("FAIL single_beat: got idx %0d res %0d expected 5 5",
                         beat_idx[0], beat_res[0]);
            end
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL single_done: got %0d pulses expected 1", done_cnt - d0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_range();
        int exp_r[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
        beat_idx.delete();
        beat_res.delete();
        core_lat = 0;
        start_run(0, 7);
        wait_done(200, "range");
        vectors++;
        if (beat_idx.size() != 8) begin
            miscompares++;
            $display("FAIL range_count: got %0d beats expected 8", beat_idx.size());
        end
        for (int k = 0; k < 8 && k < beat_idx.size(); k++) begin
            vectors++;
            if (beat_idx[k] != k || beat_res[k] != exp_r[k]) begin
                miscompares++;
                $display("FAIL range_beat%0d: got idx %0d res %0d expected %0d %0d",
                         k, beat_idx[k], beat_res[k], k, exp_r[k]);
            end
        end
        core_lat = 2;
    endtask

    task automatic test_backpressure();
        bit seen;
        beat_idx.delete();
        beat_res.delete();
        out_ready = 1'b0;
        start_run(2, 3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_valid_timeout: out_valid not seen in 50 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || fibo_start !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid %b start %b expected 1 0",
                         i, out_valid, fibo_start);
            end
            vectors++;
            if (out_idx !== 5'd2 || out_result !== 20'd1) begin
                miscompares++;
                $display("FAIL bp_data%0d: got idx %0d res %0d expected 2 1",
                         i, out_idx, out_result);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (fibo_start !== 1'b1 || fibo_i !== 5'd3 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next_req: got start %b i %0d valid %b expected 1 3 0",
                     fibo_start, fibo_i, out_valid);
        end
        wait_done(100, "bp");
        vectors++;
        if (beat_idx.size() != 2) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats expected 2", beat_idx.size());
        end else begin
            vectors++;
            if (beat_idx[1] != 3 || beat_res[1] != 2) begin
                miscompares++;
                $display("FAIL bp_beat2: got idx %0d res %0d expected 3 2",
                         beat_idx[1], beat_res[1]);
            end
        end
    endtask

    task automatic test_empty();
        int s0;
        s0 = start_cnt;
        beat_idx.delete();
        beat_res.delete();
        start_run(6, 3);
        vectors++;
        if (done !== 1'b1 || fibo_start !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_done: got done %b start %b expected 1 0",
                     done, fibo_start);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_after: got done %b busy %b expected 0 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (start_cnt != s0 || beat_idx.size() != 0) begin
            miscompares++;
            $display("FAIL empty_no_req: got %0d starts %0d beats expected 0 0",
                     start_cnt - s0, beat_idx.size());
        end
    endtask

    task automatic test_reset_midreq();
        beat_idx.delete();
        beat_res.delete();
        core_lat = 20;
        start_run(3, 3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (fibo_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreq_reset: got start %b busy %b valid %b expected 0 0 0",
                     fibo_start, busy, out_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        core_lat = 2;
        start_run(24, 24);
        wait_done(100, "post_reset");
        vectors++;
        if (beat_idx.size() != 1) begin
            miscompares++;
            $display("FAIL post_reset_count: got %0d beats expected 1", beat_idx.size());
        end else begin
            vectors++;
            if (beat_idx[0] != 24 || beat_res[0] != 46368) begin
                miscompares++;
                $display("FAIL post_reset_beat: got idx %0d res %0d expected 24 46368",
                         beat_idx[0], beat_res[0]);
            end
        end
    endtask

`ifdef FIBO_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        beat_idx.delete();
        beat_res.delete();
        core_dead = 1'b1;
        start_run(1, 1);
        repeat (15) @(posedge clk);
        #1;
        vectors++;
        if (timeout_err !== 1'b0 || fibo_start !== 1'b1) begin
            miscompares++;
            $display("FAIL to_early: got err %b start %b expected 0 1",
                     timeout_err, fibo_start);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (timeout_err !== 1'b1 || done !== 1'b1 || fibo_start !== 1'b0) begin
            miscompares++;
            $display("FAIL to_fire: got err %b done %b start %b expected 1 1 0",
                     timeout_err, done, fibo_start);
        end
        core_dead = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (beat_idx.size() != 0) begin
            miscompares++;
            $display("FAIL to_no_beat: got %0d beats expected 0", beat_idx.size());
        end
        start_run(1, 1);
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_clear: got %b expected 0", timeout_err);
        end
        wait_done(100, "to_retry");
        vectors++;
        if (beat_idx.size() != 1 || beat_res[0] != 1) begin
            miscompares++;
            $display("FAIL to_retry_beat: got %0d beats expected 1 with res 1",
                     beat_idx.size());
        end
    endtask
`else
    task automatic test_timeout();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_tied: got %b expected 0", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_range();
        test_backpressure();
        test_empty();
        test_reset_midreq();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
